neuron_lane_array: RTL and testbench

//   NUM_LANES parallel MAC neurons that share one streamed activation input.

---
 rtl/neuron_pkg.sv | 40 ++++
 rtl/neuron_lane.sv | 70 +++++++
 rtl/neuron_lane_array.sv | 107 ++++++++++
 tb/tb_neuron_lane_array.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared constants and rounding/saturation helper for the neuron lanes
package neuron_pkg;

  localparam logic [1:0] ACT_LINEAR = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_LEAKY  = 2'd2;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Wide enough that the rounding add can never wrap for any sane accumulator width.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] val,
    input int                      shift,
    input int                      width
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    r   = val;
    if (shift > 0) begin
      r = (val + (one <<< (shift - 1))) >>> shift;
    end
    hi = (one <<< (width - 1)) - one;
    lo = ~hi;
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_lane.sv
// rtl/neuron_lane.sv - one MAC neuron: product register, accumulator, bias/activation/saturation
module neuron_lane
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_SHIFT  = 22,
  parameter int BIAS_SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat,
  input  logic                 last,
  input  logic                 acc_en,
  input  logic                 fin,
  input  logic [1:0]           act_mode,
  input  logic [IN_WIDTH-1:0]  data,
  input  logic [IN_WIDTH-1:0]  weight,
  input  logic [IN_WIDTH-1:0]  bias,
  output logic [OUT_WIDTH-1:0] result
);

  logic signed [2*IN_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  act_val;
  logic [ACC_WIDTH-1:0]         bias_ext;
  logic [IN_WIDTH-1:0]          bias_q;
  logic [OUT_WIDTH-1:0]         sat_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      acc    <= '0;
      bias_q <= '0;
      result <= '0;
    end else begin
      if (beat) begin
        prod <= $signed(data) * $signed(weight);
      end
      if (last) begin
        bias_q <= bias;
      end
      if (fin) begin
        acc    <= '0;
        result <= sat_out;
      end else if (acc_en) begin
        acc <= acc + {{(ACC_WIDTH-2*IN_WIDTH){prod[2*IN_WIDTH-1]}}, prod};
      end
    end
  end

  always_comb begin
    bias_ext = {{(ACC_WIDTH-IN_WIDTH){bias_q[IN_WIDTH-1]}}, bias_q};
    sum      = acc + (bias_ext << BIAS_SHIFT);
    act_val  = sum;
    if (sum[ACC_WIDTH-1]) begin
      case (act_mode)
        ACT_LINEAR: act_val = sum;
        ACT_LEAKY:  act_val = sum >>> 3;
        ACT_RELU:   act_val = '0;
        default:    act_val = '0;
      endcase
    end
    sat_out = OUT_WIDTH'(sat_round({{(SAT_W-ACC_WIDTH){act_val[ACC_WIDTH-1]}}, act_val},
                                   OUT_SHIFT, OUT_WIDTH));
  end

endmodule

// File: rtl/neuron_lane_array.sv
// rtl/neuron_lane_array.sv - NUM_LANES MAC neurons sharing one streamed activation, with handshake FSM
module neuron_lane_array
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_INPUTS = 784,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_SHIFT  = 22,
  parameter int BIAS_SHIFT = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     act_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            data_in,
  input  logic [NUM_LANES*IN_WIDTH-1:0]  weight_in,
  input  logic [NUM_LANES*IN_WIDTH-1:0]  bias_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*OUT_WIDTH-1:0] data_out
);

  // A one-beat vector still needs a 1-bit counter.
  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [1:0]       act_q;
  logic             acc_en;
  logic             beat;
  logic             last;
  logic             fin;

  assign beat = in_valid && in_ready;
  assign last = beat && (count == LAST_CNT);
  assign fin  = (state == ST_FINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      count     <= '0;
      act_q     <= ACT_LINEAR;
      acc_en    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc_en <= beat;
      case (state)
        ST_ACCUM: begin
          in_ready <= 1'b1;
          if (beat) begin
            if (count == '0) begin
              act_q <= act_mode;
            end
            if (last) begin
              in_ready <= 1'b0;
              state    <= ST_DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_DRAIN: state <= ST_FINAL;
        ST_FINAL: begin
          out_valid <= 1'b1;
          count     <= '0;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    neuron_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_SHIFT (OUT_SHIFT),
      .BIAS_SHIFT(BIAS_SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .beat    (beat),
      .last    (last),
      .acc_en  (acc_en),
      .fin     (fin),
      .act_mode(act_q),
      .data    (data_in),
      .weight  (weight_in[k*IN_WIDTH +: IN_WIDTH]),
      .bias    (bias_in[k*IN_WIDTH +: IN_WIDTH]),
      .result  (data_out[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_neuron_lane_array.sv
// tb/tb_neuron_lane_array.sv - scoreboard bench for neuron_lane_array (4-beat and 200-beat instances)
module tb_neuron_lane_array;

  localparam int NA = 4;
  localparam int NB = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  a_mode, b_mode;
  logic        a_in_valid, a_in_ready, b_in_valid, b_in_ready;
  logic [15:0] a_data, b_data;
  logic [31:0] a_weight, a_bias, b_weight, b_bias;
  logic        a_out_valid, a_out_ready, b_out_valid, b_out_ready;
  logic [31:0] a_out, b_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  logic [31:0] exp_a, exp_b;

  neuron_lane_array #(.NUM_INPUTS(NA), .NUM_LANES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .act_mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data), .weight_in(a_weight), .bias_in(a_bias), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_out)
  );

  neuron_lane_array #(.NUM_INPUTS(NB), .NUM_LANES(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .act_mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data), .weight_in(b_weight), .bias_in(b_bias), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_out)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (sb_a.size() == 0) begin
        check_val("a_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_a = sb_a.pop_front();
        check_val("a_result", a_out, exp_a);
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) begin
        check_val("b_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_b = sb_b.pop_front();
        check_val("b_result", b_out, exp_b);
      end
    end
  end

  // Sends the first nbeats of a vector; only a complete vector pushes its expectation.
  task automatic send_a(input logic [3:0][15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] mode,
                        input logic [31:0] exp, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int t = 0;
      a_in_valid = 1'b1;
      a_data     = d[i];
      a_weight   = {w1, w0};
      a_mode     = (i == 0) ? mode : ~mode;
      a_bias     = (i == NA - 1) ? {b1, b0} : 32'hDEAD_BEEF;
      if (i == NA - 1) sb_a.push_back(exp);
      while (!a_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!a_in_ready) check_val("a_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [1:0] mode, input logic [31:0] exp);
    for (int i = 0; i < NB; i++) begin
      int t = 0;
      b_in_valid = 1'b1;
      b_data     = d;
      b_weight   = {w1, w0};
      b_mode     = mode;
      b_bias     = 32'h0;
      if (i == NB - 1) sb_b.push_back(exp);
      while (!b_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!b_in_ready) check_val("b_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_val("drain_timeout", 32'(sb_a.size() + sb_b.size()), 32'd0);
  endtask

  initial begin
    logic [3:0][15:0] d4k;
    logic [3:0][15:0] d_rnd;
    int t;
    d4k   = {4{16'h4000}};
    d_rnd = {16'h0000, 16'h0000, 16'h0000, 16'h0800};
    rst_n = 1'b0;
    a_mode = 2'd0; a_in_valid = 1'b0; a_data = '0; a_weight = '0; a_bias = '0; a_out_ready = 1'b1;
    b_mode = 2'd0; b_in_valid = 1'b0; b_data = '0; b_weight = '0; b_bias = '0; b_out_ready = 1'b1;

    #12;
    check_val("rst_in_ready", 32'(a_in_ready), 32'd0);
    check_val("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_val("rst_data_out", a_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("in_ready_after_rst", 32'(a_in_ready), 32'd1);

    // Basic sum plus latency: out_valid on the 3rd edge counting the accepting edge.
    send_a(d4k, 16'h4000, 16'h4000, 16'h0000, 16'h4000, 2'd1, 32'h0180_0100, NA);
    @(negedge clk);
    check_val("lat_edge1", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_edge2", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_edge3", 32'(a_out_valid), 32'd1);
    wait_idle();

    // Activations on a negative sum (lane 0) with a positive control lane (lane 1).
    send_a(d4k, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 2'd0, 32'h0100_FF00, NA);
    send_a(d4k, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 2'd1, 32'h0100_0000, NA);
    send_a(d4k, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 2'd2, 32'h0100_FFE0, NA);
    send_a(d4k, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 2'd3, 32'h0100_0000, NA);
    wait_idle();

    // Rounding: exactly half an LSB rounds up, just under half rounds down.
    send_a(d_rnd, 16'h0400, 16'h03FF, 16'h0000, 16'h0000, 2'd0, 32'h0000_0001, NA);
    wait_idle();

    // Backpressure: result held, extra beats refused.
    a_out_ready = 1'b0;
    send_a(d4k, 16'h4000, 16'h4000, 16'h0000, 16'h4000, 2'd1, 32'h0180_0100, NA);
    t = 0;
    while (!a_out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check_val("bp_valid_seen", 32'(a_out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      a_in_valid = 1'b1;
      a_data     = 16'h7FFF;
      a_weight   = 32'h7FFF_7FFF;
      @(negedge clk);
      check_val("bp_data_stable", a_out, 32'h0180_0100);
      check_val("bp_in_ready_low", 32'(a_in_ready), 32'd0);
      check_val("bp_valid_held", 32'(a_out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_in_ready_back", 32'(a_in_ready), 32'd1);
    check_val("bp_valid_dropped", 32'(a_out_valid), 32'd0);
    wait_idle();

    // Reset mid-vector discards the partial sums.
    send_a(d4k, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 2'd0, 32'h0, 2);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(a_out_valid), 32'd0);
    check_val("midrst_data_out", a_out, 32'd0);
    check_val("midrst_in_ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_a(d4k, 16'h4000, 16'h4000, 16'h0000, 16'h4000, 2'd1, 32'h0180_0100, NA);
    wait_idle();

    // Saturation over a long vector.
    send_b(16'h7FFF, 16'h7FFF, 16'h8000, 2'd0, 32'h8000_7FFF);
    send_b(16'h8000, 16'h7FFF, 16'h8000, 2'd0, 32'h7FFF_8000);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
